hud_digit_scheduler: RTL and testbench

HUD_DIGIT_SCHEDULER -- requirements
Module: hud_digit_scheduler

---
 rtl/hud_pkg.sv | 22 ++
 rtl/bcd_dd14.sv | 51 +++++
 rtl/hud_digit_scheduler.sv | 173 +++++++++++++++++
 tb/tb_hud_digit_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// Shared constants, FSM state type and saturation helper for the HUD digit scheduler.
package hud_pkg;
    localparam int NUM_FIELDS       = 3;
    localparam int DIGITS_PER_FIELD = 4;
    localparam int CELL_W           = 8;
    localparam int CELL_H           = 16;
    localparam int FIELD_W          = DIGITS_PER_FIELD * CELL_W;

    localparam logic [13:0] SAT_LIMIT = 14'd9999;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        STORE
    } conv_state_t;

    // Four BCD digits cannot express more than 9999, so larger values are clamped.
    function automatic logic [13:0] saturate14(input logic [13:0] v);
        return (v > SAT_LIMIT) ? SAT_LIMIT : v;
    endfunction
endpackage

// File: rtl/bcd_dd14.sv
// Sequential double-dabble converter: 14-bit binary (clamped to 9999) to 4 BCD digits in 14 shifts.
module bcd_dd14
    import hud_pkg::*;
(
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] value,
    output logic        done,
    output logic [15:0] bcd
);

    logic [13:0] shreg;
    logic [3:0]  count;
    logic        running;
    logic [15:0] adj;

    // done marks the final shift cycle; bcd holds the finished result from the next cycle on.
    assign done = running && (count == 4'd1);

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS_PER_FIELD; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bcd     <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            shreg   <= saturate14(value);
            bcd     <= '0;
            count   <= 4'd14;
            running <= 1'b1;
        end else if (running) begin
            bcd   <= {adj[14:0], shreg[13]};
            shreg <= {shreg[12:0], 1'b0};
            count <= count - 4'd1;
            if (count == 4'd1) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hud_digit_scheduler.sv
// Converts three HUD counters to BCD once per frame and serves digit lookups to the font renderer.
module hud_digit_scheduler
    import hud_pkg::*;
#(
    parameter logic [9:0] FX0 = 10'd560,
    parameter logic [9:0] FX1 = 10'd560,
    parameter logic [9:0] FX2 = 10'd560,
    parameter logic [9:0] FY0 = 10'd16,
    parameter logic [9:0] FY1 = 10'd40,
    parameter logic [9:0] FY2 = 10'd64
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [13:0] money,
    input  logic [13:0] lives,
    input  logic [13:0] round_num,
    output logic [3:0]  number,
    output logic [9:0]  relativeXF,
    output logic [9:0]  relativeYF,
    output logic        digit_hit,
    output logic        busy
);

    localparam logic [NUM_FIELDS-1:0][9:0] FX_TAB = {FX2, FX1, FX0};
    localparam logic [NUM_FIELDS-1:0][9:0] FY_TAB = {FY2, FY1, FY0};

    conv_state_t state;
    logic [1:0]  field;
    logic [13:0] field_value;
    logic        conv_start;
    logic        conv_done;
    logic [15:0] conv_bcd;
    logic [15:0] work_bcd    [NUM_FIELDS];
    logic [15:0] display_bcd [NUM_FIELDS];

    logic        hit_c;
    logic [1:0]  sel_c;
    logic [9:0]  rx_c;
    logic [9:0]  ry_c;
    logic [15:0] digits_c;
    logic [3:0]  num_c;
    logic        vis_c;

    always_comb begin
        case (field)
            2'd0:    field_value = money;
            2'd1:    field_value = lives;
            default: field_value = round_num;
        endcase
    end

    assign conv_start = (state == LOAD);

    bcd_dd14 u_conv (
        .vga_clk (vga_clk),
        .reset   (reset),
        .start   (conv_start),
        .value   (field_value),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    // Digits land in work_bcd per field; display_bcd only changes once all three are ready.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            field <= 2'd0;
            busy  <= 1'b0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                work_bcd[i]    <= '0;
                display_bcd[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= LOAD;
                        field <= 2'd0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: state <= SHIFT;
                SHIFT: begin
                    if (conv_done) begin
                        state <= STORE;
                    end
                end
                STORE: begin
                    work_bcd[field] <= conv_bcd;
                    if (field == 2'(NUM_FIELDS - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        for (int i = 0; i < NUM_FIELDS - 1; i++) begin
                            display_bcd[i] <= work_bcd[i];
                        end
                        display_bcd[NUM_FIELDS-1] <= conv_bcd;
                    end else begin
                        field <= field + 2'd1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Walk fields from highest to lowest so the lowest-indexed overlapping field wins.
    always_comb begin
        hit_c = 1'b0;
        sel_c = 2'd0;
        rx_c  = '0;
        ry_c  = '0;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            if (({1'b0, DrawX} >= {1'b0, FX_TAB[i]}) &&
                ({1'b0, DrawX} <  {1'b0, FX_TAB[i]} + 11'(FIELD_W)) &&
                ({1'b0, DrawY} >= {1'b0, FY_TAB[i]}) &&
                ({1'b0, DrawY} <  {1'b0, FY_TAB[i]} + 11'(CELL_H))) begin
                hit_c = 1'b1;
                sel_c = 2'(i);
                rx_c  = DrawX - FX_TAB[i];
                ry_c  = DrawY - FY_TAB[i];
            end
        end
    end

    // A cell is shown if it is the units digit or any digit at or left of it is nonzero.
    always_comb begin
        digits_c = display_bcd[sel_c];
        num_c    = 4'd0;
        vis_c    = 1'b0;
        case (rx_c[4:3])
            2'd0: begin
                num_c = digits_c[15:12];
                vis_c = |digits_c[15:12];
            end
            2'd1: begin
                num_c = digits_c[11:8];
                vis_c = |digits_c[15:8];
            end
            2'd2: begin
                num_c = digits_c[7:4];
                vis_c = |digits_c[15:4];
            end
            default: begin
                num_c = digits_c[3:0];
                vis_c = 1'b1;
            end
        endcase
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            number     <= '0;
            relativeXF <= '0;
            relativeYF <= '0;
            digit_hit  <= 1'b0;
        end else if (hit_c) begin
            number     <= num_c;
            relativeXF <= rx_c;
            relativeYF <= ry_c;
            digit_hit  <= vis_c;
        end else begin
            number     <= '0;
            relativeXF <= '0;
            relativeYF <= '0;
            digit_hit  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hud_digit_scheduler.sv
// Directed scoreboard bench for hud_digit_scheduler: conversion passes, blanking, box edges, reset abort.
module tb_hud_digit_scheduler;

    localparam int FX [3] = '{560, 560, 560};
    localparam int FY [3] = '{16, 40, 64};
    localparam int POW10 [4] = '{1000, 100, 10, 1};

    typedef struct {
        logic [3:0] number;
        logic [9:0] rx;
        logic [9:0] ry;
        logic       hit;
    } exp_t;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [13:0] money = '0;
    logic [13:0] lives = '0;
    logic [13:0] round_num = '0;
    logic [3:0]  number;
    logic [9:0]  relativeXF;
    logic [9:0]  relativeYF;
    logic        digit_hit;
    logic        busy;

    int   checks_total = 0;
    int   checks_passed = 0;
    int   model_val [3] = '{0, 0, 0};
    exp_t sb [$];

    hud_digit_scheduler dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_start (frame_start),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .money       (money),
        .lives       (lives),
        .round_num   (round_num),
        .number      (number),
        .relativeXF  (relativeXF),
        .relativeYF  (relativeYF),
        .digit_hit   (digit_hit),
        .busy        (busy)
    );

    always #5 vga_clk = ~vga_clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Decimal reference for what the pixel lookup should return.
    function automatic exp_t model_pixel(input int x, input int y);
        exp_t e;
        int   f;
        int   v;
        int   idx;
        e.number = '0;
        e.rx     = '0;
        e.ry     = '0;
        e.hit    = 1'b0;
        f = -1;
        for (int i = 2; i >= 0; i--) begin
            if (x >= FX[i] && x < FX[i] + 32 && y >= FY[i] && y < FY[i] + 16) f = i;
        end
        if (f >= 0) begin
            v = (model_val[f] > 9999) ? 9999 : model_val[f];
            idx = (x - FX[f]) / 8;
            e.rx     = 10'(x - FX[f]);
            e.ry     = 10'(y - FY[f]);
            e.number = 4'((v / POW10[idx]) % 10);
            e.hit    = (idx == 3) || (v >= POW10[idx]);
        end
        return e;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks_total++;
        assert (obs === expv) checks_passed++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic apply_pixel(input int x, input int y, input string tag);
        exp_t e;
        DrawX = 10'(x);
        DrawY = 10'(y);
        sb.push_back(model_pixel(x, y));
        @(posedge vga_clk);
        #1;
        e = sb.pop_front();
        check_output({tag, ".number"}, 32'(number), 32'(e.number));
        check_output({tag, ".relX"}, 32'(relativeXF), 32'(e.rx));
        check_output({tag, ".relY"}, 32'(relativeYF), 32'(e.ry));
        check_output({tag, ".hit"}, 32'(digit_hit), 32'(e.hit));
    endtask

    // Runs one pass; glitch_at >= 0 injects an extra frame_start that many cycles in.
    task automatic apply_stimulus(input int glitch_at, input string tag);
        int cycles;
        frame_start = 1'b1;
        @(posedge vga_clk);
        #1;
        frame_start = 1'b0;
        check_output({tag, ".busy_rise"}, 32'(busy), 32'd1);
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            frame_start = (cycles == glitch_at);
            @(posedge vga_clk);
            #1;
            cycles++;
        end
        frame_start = 1'b0;
        check_output({tag, ".pass_len"}, 32'(cycles), 32'd48);
        model_val[0] = int'(money);
        model_val[1] = int'(lives);
        model_val[2] = int'(round_num);
    endtask

    initial begin
        repeat (3) @(posedge vga_clk);
        #1;
        check_output("rst.busy", 32'(busy), 32'd0);
        check_output("rst.number", 32'(number), 32'd0);
        check_output("rst.hit", 32'(digit_hit), 32'd0);
        check_output("rst.relX", 32'(relativeXF), 32'd0);
        check_output("rst.relY", 32'(relativeYF), 32'd0);
        reset = 1'b0;
        @(posedge vga_clk);
        #1;

        apply_pixel(FX[0] + 24, FY[0] + 2, "rst_f0_c3");
        apply_pixel(FX[0] + 0, FY[0] + 2, "rst_f0_c0");

        money = 14'd1234;
        lives = 14'd7;
        round_num = 14'd0;
        apply_stimulus(-1, "pass1");
        apply_pixel(FX[0] + 8, FY[0] + 3, "m1234_c1");
        apply_pixel(FX[0] + 0, FY[0] + 3, "m1234_c0");
        apply_pixel(FX[0] + 27, FY[0] + 9, "m1234_c3");
        for (int c = 0; c < 4; c++) apply_pixel(FX[1] + 8 * c + 2, FY[1] + 5, $sformatf("lives7_c%0d", c));
        apply_pixel(FX[2] + 0, FY[2] + 1, "round0_c0");
        apply_pixel(FX[2] + 25, FY[2] + 1, "round0_c3");

        apply_pixel(FX[0] + 31, FY[0] + 15, "edge_in");
        apply_pixel(FX[0] + 32, FY[0], "edge_right");
        apply_pixel(FX[0], FY[0] + 16, "edge_below");
        apply_pixel(FX[0] - 1, FY[0], "edge_left");

        money = 14'd12000;
        lives = 14'd0;
        round_num = 14'd305;
        apply_stimulus(-1, "pass2");
        for (int c = 0; c < 4; c++) apply_pixel(FX[0] + 8 * c + 4, FY[0] + 7, $sformatf("sat_c%0d", c));
        for (int c = 0; c < 4; c++) apply_pixel(FX[1] + 8 * c, FY[1], $sformatf("lives0_c%0d", c));
        for (int c = 0; c < 4; c++) apply_pixel(FX[2] + 8 * c + 7, FY[2] + 15, $sformatf("r305_c%0d", c));

        money = 14'd4321;
        lives = 14'd56;
        round_num = 14'd9;
        apply_stimulus(10, "pass_glitch");
        for (int c = 0; c < 4; c++) apply_pixel(FX[0] + 8 * c + 1, FY[0] + 1, $sformatf("glitch_c%0d", c));
        apply_pixel(FX[1] + 16, FY[1] + 4, "glitch_l_c2");
        apply_pixel(FX[2] + 24, FY[2] + 4, "glitch_r_c3");

        money = 14'd1111;
        lives = 14'd1111;
        round_num = 14'd1111;
        frame_start = 1'b1;
        @(posedge vga_clk);
        #1;
        frame_start = 1'b0;
        for (int c = 1; c < 30; c++) begin
            if (c == 5) begin
                money = 14'd2222;
                lives = 14'd2222;
                round_num = 14'd2222;
            end
            @(posedge vga_clk);
            #1;
        end
        check_output("abort.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_output("abort.busy", 32'(busy), 32'd0);
        check_output("abort.hit", 32'(digit_hit), 32'd0);
        model_val = '{0, 0, 0};
        @(posedge vga_clk);
        #1;
        reset = 1'b0;
        for (int f = 0; f < 3; f++) begin
            apply_pixel(FX[f] + 26, FY[f] + 3, $sformatf("abort_f%0d_c3", f));
            apply_pixel(FX[f] + 2, FY[f] + 3, $sformatf("abort_f%0d_c0", f));
        end

        apply_stimulus(-1, "pass_recover");
        for (int f = 0; f < 3; f++) apply_pixel(FX[f] + 10, FY[f] + 8, $sformatf("recover_f%0d_c1", f));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
